// File: rtl/i2c_peripheral_regs.sv
// Register/buffer block behind the I2C peripheral protocol engine: mailboxes,
// direction FIFOs, engine configuration and a byte-wide host register port.

module i2c_peripheral_regs_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push   = push && (!full || do_pop);
  assign overflow  = push && !do_push;
  assign underflow = pop && empty;
  assign head      = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module i2c_peripheral_regs #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  ID_VALUE   = 8'hDA
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] i2c_reg_addr_i,
  input  logic [7:0] i2c_reg_wdata_i,
  input  logic       i2c_reg_wrenable_i,
  input  logic       i2c_reg_rd_byte_complete_i,
  output logic [7:0] i2c_reg_rddata_o,
  output logic [6:0] i2c_dev_addr_o,
  output logic       i2c_enabled_o,
  output logic [7:0] i2c_debounce_len_o,
  output logic [7:0] i2c_scl_delay_len_o,
  output logic [7:0] i2c_sda_delay_len_o,
  input  logic [7:0] host_addr_i,
  input  logic [7:0] host_wdata_i,
  input  logic       host_we_i,
  input  logic       host_re_i,
  output logic [7:0] host_rdata_o,
  output logic       host_irq_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [7:0] I2C_ID      = 8'h00;
  localparam logic [7:0] I2C_M2H_MB  = 8'h10;
  localparam logic [7:0] I2C_H2M_MB  = 8'h11;
  localparam logic [7:0] I2C_STATUS  = 8'h12;
  localparam logic [7:0] I2C_RX_PUSH = 8'h20;
  localparam logic [7:0] I2C_RX_FREE = 8'h21;
  localparam logic [7:0] I2C_TX_HEAD = 8'h30;
  localparam logic [7:0] I2C_TX_CNT  = 8'h31;

  localparam logic [7:0] H_CTRL     = 8'h00;
  localparam logic [7:0] H_DEV_ADDR = 8'h01;
  localparam logic [7:0] H_DEBOUNCE = 8'h02;
  localparam logic [7:0] H_SCL_DLY  = 8'h03;
  localparam logic [7:0] H_SDA_DLY  = 8'h04;
  localparam logic [7:0] H_MAILBOX  = 8'h10;
  localparam logic [7:0] H_STATUS   = 8'h11;
  localparam logic [7:0] H_FIFO     = 8'h20;
  localparam logic [7:0] H_COUNT    = 8'h21;
  localparam logic [7:0] H_IRQ_MASK = 8'h30;

  logic          m2h_wr, rx_push, h2m_rd, tx_pop;
  logic          host_m2h_rd, host_h2m_wr, host_stat_wr, host_tx_push, host_rx_pop;
  logic [7:0]    m2h_data, h2m_data;
  logic          m2h_full, h2m_full, h2m_empty_evt;
  logic          ovf_flag, udf_flag;
  logic [3:0]    irq_mask;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_full, tx_empty, tx_ovf, tx_udf;
  logic          rx_full, rx_empty, rx_ovf, rx_udf;
  logic [7:0]    status;
  logic [7:0]    host_rdata_next;

  assign m2h_wr       = i2c_reg_wrenable_i && (i2c_reg_addr_i == I2C_M2H_MB);
  assign rx_push      = i2c_reg_wrenable_i && (i2c_reg_addr_i == I2C_RX_PUSH);
  assign h2m_rd       = i2c_reg_rd_byte_complete_i && (i2c_reg_addr_i == I2C_H2M_MB);
  assign tx_pop       = i2c_reg_rd_byte_complete_i && (i2c_reg_addr_i == I2C_TX_HEAD);
  assign host_m2h_rd  = host_re_i && (host_addr_i == H_MAILBOX);
  assign host_h2m_wr  = host_we_i && (host_addr_i == H_MAILBOX);
  assign host_stat_wr = host_we_i && (host_addr_i == H_STATUS);
  assign host_tx_push = host_we_i && (host_addr_i == H_FIFO);
  assign host_rx_pop  = host_re_i && (host_addr_i == H_FIFO);

  // tx = host->I2C (bytes the engine transmits), rx = I2C->host.
  i2c_peripheral_regs_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (host_tx_push),
    .wdata     (host_wdata_i),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty),
    .overflow  (tx_ovf),
    .underflow (tx_udf)
  );

  i2c_peripheral_regs_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (rx_push),
    .wdata     (i2c_reg_wdata_i),
    .pop       (host_rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty),
    .overflow  (rx_ovf),
    .underflow (rx_udf)
  );

  assign status = {4'b0000, rx_empty, tx_full, h2m_full, m2h_full};

  always_comb begin
    i2c_reg_rddata_o = '0;
    case (i2c_reg_addr_i)
      I2C_ID:      i2c_reg_rddata_o = ID_VALUE;
      I2C_H2M_MB:  i2c_reg_rddata_o = h2m_data;
      I2C_STATUS:  i2c_reg_rddata_o = status;
      I2C_RX_FREE: i2c_reg_rddata_o = 8'(CW'(FIFO_DEPTH) - rx_count);
      I2C_TX_HEAD: i2c_reg_rddata_o = tx_head;
      I2C_TX_CNT:  i2c_reg_rddata_o = 8'(tx_count);
      default:     i2c_reg_rddata_o = '0;
    endcase
  end

  always_comb begin
    host_rdata_next = '0;
    case (host_addr_i)
      H_CTRL:     host_rdata_next = {7'b0, i2c_enabled_o};
      H_DEV_ADDR: host_rdata_next = {1'b0, i2c_dev_addr_o};
      H_DEBOUNCE: host_rdata_next = i2c_debounce_len_o;
      H_SCL_DLY:  host_rdata_next = i2c_scl_delay_len_o;
      H_SDA_DLY:  host_rdata_next = i2c_sda_delay_len_o;
      H_MAILBOX:  host_rdata_next = m2h_data;
      H_STATUS:   host_rdata_next = {2'b00, udf_flag, ovf_flag, status[3:0]};
      H_FIFO:     host_rdata_next = rx_head;
      H_COUNT:    host_rdata_next = {2'b00, 6'(rx_count)};
      H_IRQ_MASK: host_rdata_next = {4'b0000, irq_mask};
      default:    host_rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i2c_enabled_o       <= 1'b0;
      i2c_dev_addr_o      <= '0;
      i2c_debounce_len_o  <= '0;
      i2c_scl_delay_len_o <= '0;
      i2c_sda_delay_len_o <= '0;
      irq_mask            <= '0;
    end else if (host_we_i) begin
      case (host_addr_i)
        H_CTRL:     i2c_enabled_o       <= host_wdata_i[0];
        H_DEV_ADDR: i2c_dev_addr_o      <= host_wdata_i[6:0];
        H_DEBOUNCE: i2c_debounce_len_o  <= host_wdata_i;
        H_SCL_DLY:  i2c_scl_delay_len_o <= host_wdata_i;
        H_SDA_DLY:  i2c_sda_delay_len_o <= host_wdata_i;
        H_IRQ_MASK: irq_mask            <= host_wdata_i[3:0];
        default:    ;
      endcase
    end
  end

  // Writers take priority over readers on both mailboxes; the reader still sees the old byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m2h_data      <= '0;
      m2h_full      <= 1'b0;
      h2m_data      <= '0;
      h2m_full      <= 1'b0;
      h2m_empty_evt <= 1'b0;
    end else begin
      if (m2h_wr) begin
        m2h_data <= i2c_reg_wdata_i;
        m2h_full <= 1'b1;
      end else if (host_m2h_rd) begin
        m2h_full <= 1'b0;
      end
      if (host_h2m_wr) begin
        h2m_data      <= host_wdata_i;
        h2m_full      <= 1'b1;
        h2m_empty_evt <= 1'b0;
      end else if (h2m_rd && h2m_full) begin
        h2m_full      <= 1'b0;
        h2m_empty_evt <= 1'b1;
      end
    end
  end

  // Error flags collect both FIFO directions; a new event wins over a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_flag     <= 1'b0;
      udf_flag     <= 1'b0;
      host_rdata_o <= '0;
      host_irq_o   <= 1'b0;
    end else begin
      ovf_flag <= (ovf_flag & ~(host_stat_wr & host_wdata_i[4])) | tx_ovf | rx_ovf;
      udf_flag <= (udf_flag & ~(host_stat_wr & host_wdata_i[5])) | tx_udf | rx_udf;
      if (host_re_i) host_rdata_o <= host_rdata_next;
      host_irq_o <= |(irq_mask & {ovf_flag | udf_flag, h2m_empty_evt, ~rx_empty, m2h_full});
    end
  end

  logic unused;
  assign unused = rx_full ^ tx_empty;
endmodule

// File: tb/tb_i2c_peripheral_regs.sv
// Directed self-checking bench for i2c_peripheral_regs (FIFO_DEPTH = 8).
module tb_i2c_peripheral_regs;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i2c_addr = '0;
  logic [7:0] i2c_wdata = '0;
  logic       i2c_we = 1'b0;
  logic       i2c_rbc = 1'b0;
  logic [7:0] i2c_rdata;
  logic [6:0] dev_addr;
  logic       enabled;
  logic [7:0] debounce, scl_dly, sda_dly;
  logic [7:0] h_addr = '0;
  logic [7:0] h_wdata = '0;
  logic       h_we = 1'b0;
  logic       h_re = 1'b0;
  logic [7:0] h_rdata;
  logic       irq;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  i2c_peripheral_regs #(.FIFO_DEPTH(8), .ID_VALUE(8'hDA)) dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .i2c_reg_addr_i             (i2c_addr),
    .i2c_reg_wdata_i            (i2c_wdata),
    .i2c_reg_wrenable_i         (i2c_we),
    .i2c_reg_rd_byte_complete_i (i2c_rbc),
    .i2c_reg_rddata_o           (i2c_rdata),
    .i2c_dev_addr_o             (dev_addr),
    .i2c_enabled_o              (enabled),
    .i2c_debounce_len_o         (debounce),
    .i2c_scl_delay_len_o        (scl_dly),
    .i2c_sda_delay_len_o        (sda_dly),
    .host_addr_i                (h_addr),
    .host_wdata_i               (h_wdata),
    .host_we_i                  (h_we),
    .host_re_i                  (h_re),
    .host_rdata_o               (h_rdata),
    .host_irq_o                 (irq)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    h_addr = a; h_wdata = d; h_we = 1'b1;
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    h_addr = a; h_re = 1'b1;
    @(negedge clk);
    h_re = 1'b0;
    d = h_rdata;
  endtask

  task automatic i2c_write(input logic [7:0] a, input logic [7:0] d);
    i2c_addr = a; i2c_wdata = d; i2c_we = 1'b1;
    @(negedge clk);
    i2c_we = 1'b0;
  endtask

  task automatic i2c_peek(input logic [7:0] a, output logic [7:0] d);
    i2c_addr = a;
    #1;
    d = i2c_rdata;
  endtask

  task automatic i2c_pop(input logic [7:0] a, output logic [7:0] d);
    i2c_addr = a;
    #1;
    d = i2c_rdata;
    i2c_rbc = 1'b1;
    @(negedge clk);
    i2c_rbc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;

    // reset
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst_dev_addr", {1'b0, dev_addr}, 8'h00);
    check("rst_enabled", {7'b0, enabled}, 8'h00);
    check("rst_debounce", debounce, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_host_rdata", h_rdata, 8'h00);
    i2c_peek(8'h12, d); check("rst_i2c_status", d, 8'h08);
    i2c_peek(8'h21, d); check("rst_rx_free", d, 8'h08);
    i2c_peek(8'h31, d); check("rst_tx_count", d, 8'h00);

    // configuration
    host_write(8'h01, 8'h3C);
    host_write(8'h00, 8'h01);
    check("cfg_dev_addr", {1'b0, dev_addr}, 8'h3C);
    check("cfg_enabled", {7'b0, enabled}, 8'h01);
    host_write(8'h02, 8'h11);
    host_write(8'h03, 8'h22);
    host_write(8'h04, 8'h33);
    check("cfg_debounce", debounce, 8'h11);
    check("cfg_scl", scl_dly, 8'h22);
    check("cfg_sda", sda_dly, 8'h33);
    host_read(8'h01, d); check("host_rd_dev_addr", d, 8'h3C);
    i2c_peek(8'h00, d); check("i2c_id", d, 8'hDA);
    i2c_peek(8'h55, d); check("i2c_unmapped", d, 8'h00);
    host_read(8'h7F, d); check("host_unmapped", d, 8'h00);

    // I2C->host mailbox with irq
    host_write(8'h30, 8'h01);
    i2c_write(8'h10, 8'hA5);
    i2c_peek(8'h12, d); check("mb_status", d, 8'h09);
    @(negedge clk);
    check("mb_irq_set", {7'b0, irq}, 8'h01);
    host_read(8'h10, d); check("mb_host_read", d, 8'hA5);
    @(negedge clk);
    check("mb_irq_drop", {7'b0, irq}, 8'h00);

    // host->I2C FIFO overfill and drain past empty
    for (int i = 1; i <= 9; i++) host_write(8'h20, 8'(i));
    i2c_peek(8'h31, d); check("tx_count_full", d, 8'h08);
    i2c_peek(8'h12, d); check("tx_i2c_status_full", d, 8'h0C);
    host_read(8'h11, d); check("tx_host_status_ovf", d, 8'h1C);
    for (int i = 1; i <= 8; i++) begin
      i2c_pop(8'h30, d); check("tx_pop_data", d, 8'(i));
    end
    i2c_pop(8'h30, d); check("tx_pop_empty", d, 8'h00);
    host_read(8'h11, d); check("tx_host_status_udf", d, 8'h38);
    i2c_peek(8'h31, d); check("tx_count_empty", d, 8'h00);
    host_write(8'h11, 8'h30);
    host_read(8'h11, d); check("status_w1c", d, 8'h08);

    // host->I2C mailbox collision and empty event irq
    host_write(8'h10, 8'h55);
    i2c_addr = 8'h11; i2c_rbc = 1'b1;
    h_addr = 8'h10; h_wdata = 8'h77; h_we = 1'b1;
    @(negedge clk);
    i2c_rbc = 1'b0; h_we = 1'b0;
    i2c_peek(8'h12, d); check("coll_status", d, 8'h0A);
    i2c_pop(8'h11, d); check("coll_data", d, 8'h77);
    i2c_peek(8'h12, d); check("h2m_cleared", d, 8'h08);
    host_write(8'h30, 8'h04);
    @(negedge clk);
    check("h2m_evt_irq", {7'b0, irq}, 8'h01);
    host_write(8'h10, 8'h12);
    @(negedge clk);
    check("h2m_evt_clr_irq", {7'b0, irq}, 8'h00);

    // full host->I2C FIFO: simultaneous push/pop, no overflow
    for (int i = 0; i < 8; i++) host_write(8'h20, 8'hB0 + 8'(i));
    i2c_addr = 8'h30; #1; d = i2c_rdata;
    check("full_sim_head", d, 8'hB0);
    h_addr = 8'h20; h_wdata = 8'hB8; h_we = 1'b1; i2c_rbc = 1'b1;
    @(negedge clk);
    h_we = 1'b0; i2c_rbc = 1'b0;
    i2c_peek(8'h31, d); check("full_sim_count", d, 8'h08);
    host_read(8'h11, d); check("full_sim_no_ovf", d, 8'h0E);
    for (int i = 1; i <= 8; i++) begin
      i2c_pop(8'h30, d); check("full_sim_order", d, 8'hB0 + 8'(i));
    end

    // I2C->host FIFO: simultaneous push and pop across pointer wrap
    host_write(8'h30, 8'h00);
    for (int i = 0; i < 3; i++) i2c_write(8'h20, 8'h40 + 8'(i));
    host_read(8'h21, d); check("rx_count3", d, 8'h03);
    for (int k = 0; k < 20; k++) begin
      i2c_addr = 8'h20; i2c_wdata = 8'h43 + 8'(k); i2c_we = 1'b1;
      h_addr = 8'h20; h_re = 1'b1;
      @(negedge clk);
      i2c_we = 1'b0; h_re = 1'b0;
      check("rx_sim_pop", h_rdata, 8'h40 + 8'(k));
      i2c_peek(8'h21, d); check("rx_sim_free", d, 8'h05);
    end
    host_read(8'h21, d); check("rx_count_after", d, 8'h03);
    for (int i = 0; i < 3; i++) begin
      host_read(8'h20, d); check("rx_drain", d, 8'h54 + 8'(i));
    end

    // reset mid-operation
    for (int i = 0; i < 4; i++) i2c_write(8'h20, 8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) host_write(8'h20, 8'hD0 + 8'(i));
    host_write(8'h30, 8'h02);
    @(negedge clk);
    check("pre_rst_irq", {7'b0, irq}, 8'h01);
    host_read(8'h21, d); check("pre_rst_rx_count", d, 8'h04);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_irq", {7'b0, irq}, 8'h00);
    check("mid_rst_enabled", {7'b0, enabled}, 8'h00);
    check("mid_rst_dev_addr", {1'b0, dev_addr}, 8'h00);
    check("mid_rst_scl", scl_dly, 8'h00);
    check("mid_rst_host_rdata", h_rdata, 8'h00);
    i2c_peek(8'h31, d); check("mid_rst_tx_count", d, 8'h00);
    i2c_peek(8'h21, d); check("mid_rst_rx_free", d, 8'h08);
    @(negedge clk);
    check("mid_rst_irq_after", {7'b0, irq}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
